// File: rtl/pbm_wr_ctrl.sv
// pbm_wr_ctrl: packet-buffer write controller. Beats are written speculatively
// into a word ring; good packets are committed as descriptors, bad or
// overflowing packets are rolled back so the consumer only sees whole packets.
module pbm_wr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DESC_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wvalid,
    input  logic                  s_wlast,
    input  logic                  s_werror,
    output logic                  s_ready,
    input  logic [15:0]           i_meta_data,
    input  logic                  i_meta_valid,
    output logic                  o_meta_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_desc_valid,
    output logic [ADDR_WIDTH-1:0] o_desc_addr,
    output logic [ADDR_WIDTH:0]   o_desc_words,
    output logic [15:0]           o_desc_len,
    input  logic                  i_desc_ready,
    input  logic                  i_free_valid,
    input  logic [ADDR_WIDTH:0]   i_free_words,
    output logic [ADDR_WIDTH:0]   o_free_cnt,
    output logic [15:0]           o_drop_cnt,
    output logic                  o_free_err
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int FW = $clog2(DESC_DEPTH);
    localparam logic [PW-1:0] RING_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [FW:0]   FIFO_FULL  = {1'b1, {FW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [PW-1:0]         words;
        logic [15:0]           len;
    } desc_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         start_q, start_d;
    logic [PW-1:0]         free_cnt_q, free_cnt_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  free_err_q, free_err_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [FW:0]           fifo_wr_q, fifo_wr_d;
    logic [FW:0]           fifo_rd_q, fifo_rd_d;

    desc_t                 fifo_mem [DESC_DEPTH];
    desc_t                 head;
    desc_t                 push_entry;
    logic                  push, pop, drop, beat;
    logic                  fifo_empty, fifo_full;
    logic [PW-1:0]         space;
    logic [PW-1:0]         pkt_start;

    assign fifo_empty = (fifo_wr_q == fifo_rd_q);
    assign fifo_full  = ((fifo_wr_q - fifo_rd_q) == FIFO_FULL);
    assign pop        = i_desc_ready && !fifo_empty;
    assign head       = fifo_mem[fifo_rd_q[FW-1:0]];

    // New packets are only started when a descriptor slot is guaranteed.
    assign s_ready = !rst && ((state_q != IDLE) || !fifo_full);
    assign beat    = s_wvalid && s_ready;

    // Next-state: beat handling, commit/rollback, free requests and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        start_d      = start_q;
        drop_cnt_d   = drop_cnt_q;
        free_err_d   = free_err_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        push         = 1'b0;
        push_entry   = '0;
        o_meta_ready = 1'b0;
        drop         = 1'b0;
        space        = RING_WORDS - (wr_ptr_q - rd_ptr_q);
        pkt_start    = (state_q == IDLE) ? commit_ptr_q : start_q;

        if (beat) begin
            start_d = pkt_start;
            if (state_q == DISCARD) begin
                if (s_wlast) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end else if (space == '0) begin
                // Ring is full: abandon the packet and release its words now.
                wr_ptr_d = commit_ptr_q;
                if (s_wlast) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                mem_we_d    = 1'b1;
                mem_waddr_d = wr_ptr_q[ADDR_WIDTH-1:0];
                mem_wdata_d = s_wdata;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                state_d     = WRITE;
                if (s_wlast) begin
                    state_d = IDLE;
                    if (!s_werror && i_meta_valid) begin
                        commit_ptr_d     = wr_ptr_q + 1'b1;
                        push             = 1'b1;
                        push_entry.addr  = pkt_start[ADDR_WIDTH-1:0];
                        push_entry.words = wr_ptr_q + 1'b1 - pkt_start;
                        push_entry.len   = i_meta_data;
                        o_meta_ready     = 1'b1;
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        drop     = 1'b1;
                    end
                end
            end
        end

        if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;

        // Only committed, not-yet-released words may be freed.
        if (i_free_valid) begin
            if (i_free_words <= (commit_ptr_q - rd_ptr_q))
                rd_ptr_d = rd_ptr_q + i_free_words;
            else
                free_err_d = 1'b1;
        end

        free_cnt_d = RING_WORDS - (wr_ptr_d - rd_ptr_d);
        fifo_wr_d  = push ? fifo_wr_q + 1'b1 : fifo_wr_q;
        fifo_rd_d  = pop  ? fifo_rd_q + 1'b1 : fifo_rd_q;
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            start_q      <= '0;
            free_cnt_q   <= RING_WORDS;
            drop_cnt_q   <= '0;
            free_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_q      <= start_d;
            free_cnt_q   <= free_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            free_err_q   <= free_err_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
        end
    end

    // Descriptor storage; contents are don't-care until the pointers say valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wr_q[FW-1:0]] <= push_entry;
    end

    assign o_mem_we     = mem_we_q;
    assign o_mem_waddr  = mem_waddr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_desc_valid = !fifo_empty;
    assign o_desc_addr  = fifo_empty ? '0 : head.addr;
    assign o_desc_words = fifo_empty ? '0 : head.words;
    assign o_desc_len   = fifo_empty ? '0 : head.len;
    assign o_free_cnt   = free_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_free_err   = free_err_q;

endmodule

// File: tb/tb_pbm_wr_ctrl.sv
// tb_pbm_wr_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model of the ring (unbounded integer pointers).
module tb_pbm_wr_ctrl;
    localparam int AW = 4, DW = 32, DD = 4, RING = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] s_wdata = '0;
    logic          s_wvalid = 1'b0, s_wlast = 1'b0, s_werror = 1'b0, s_ready;
    logic [15:0]   i_meta_data = '0;
    logic          i_meta_valid = 1'b0, o_meta_ready;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_waddr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_desc_valid;
    logic [AW-1:0] o_desc_addr;
    logic [AW:0]   o_desc_words;
    logic [15:0]   o_desc_len;
    logic          i_desc_ready = 1'b0, i_free_valid = 1'b0;
    logic [AW:0]   i_free_words = '0;
    logic [AW:0]   o_free_cnt;
    logic [15:0]   o_drop_cnt;
    logic          o_free_err;

    always #5 clk = ~clk;

    pbm_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESC_DEPTH(DD)) dut (
        .clk(clk), .rst(rst), .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
        .s_werror(s_werror), .s_ready(s_ready), .i_meta_data(i_meta_data),
        .i_meta_valid(i_meta_valid), .o_meta_ready(o_meta_ready), .o_mem_we(o_mem_we),
        .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .o_desc_valid(o_desc_valid),
        .o_desc_addr(o_desc_addr), .o_desc_words(o_desc_words), .o_desc_len(o_desc_len),
        .i_desc_ready(i_desc_ready), .i_free_valid(i_free_valid), .i_free_words(i_free_words),
        .o_free_cnt(o_free_cnt), .o_drop_cnt(o_drop_cnt), .o_free_err(o_free_err)
    );

    int checks = 0, errors = 0;

    // Reference model: pointers never wrap, RAM address is pointer mod RING.
    typedef struct { int addr; int words; int len; } desc_m_t;
    int      m_wr, m_commit, m_rd, m_start, m_drop, m_meta, m_state; // state 0 idle,1 pkt,2 discard
    bit      m_ferr;
    desc_m_t m_desc[$];
    logic [AW+DW-1:0] exp_wr[$], got_wr[$];
    int      got_meta;

    logic          pv;
    logic [AW-1:0] pa;
    logic [AW:0]   pw;
    logic [15:0]   pl;
    desc_m_t       ed;

    // Collect RAM writes and meta pulses as they appear.
    always @(negedge clk) begin
        if (o_mem_we === 1'b1) got_wr.push_back({o_mem_waddr, o_mem_wdata});
        if (o_meta_ready === 1'b1) got_meta++;
    end

    task automatic model_reset();
        m_wr = 0; m_commit = 0; m_rd = 0; m_start = 0; m_drop = 0; m_meta = 0;
        m_state = 0; m_ferr = 0; got_meta = 0;
        m_desc.delete(); exp_wr.delete(); got_wr.delete();
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input bit last, input bit err,
                              input bit mv, input int meta);
        if (m_state == 0) m_start = m_commit;
        if (m_state == 2) begin
            if (last) begin m_drop++; m_state = 0; end
        end else if (RING - (m_wr - m_rd) == 0) begin
            m_wr = m_commit;
            if (last) begin m_drop++; m_state = 0; end else m_state = 2;
        end else begin
            exp_wr.push_back({4'(m_wr % RING), d});
            m_wr++;
            m_state = 1;
            if (last) begin
                m_state = 0;
                if (!err && mv) begin
                    m_desc.push_back('{m_start % RING, m_wr - m_start, meta});
                    m_commit = m_wr;
                    m_meta++;
                end else begin
                    m_wr = m_commit;
                    m_drop++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_wvalid = 1'b0; i_desc_ready = 1'b0; i_free_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit err,
                             input bit mv, input int meta);
        int n;
        s_wdata = d; s_wlast = last; s_werror = err; i_meta_valid = mv;
        i_meta_data = 16'(meta); s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (s_ready !== 1'b1 && n < 50);
        if (s_ready === 1'b1) begin
            model_beat(d, last, err, mv, meta);
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got %b required 1 within 50 cycles", s_ready);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_werror = 1'b0; i_meta_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [DW-1:0] base, input bit err,
                            input bit mv, input int meta, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 4 == 0)) idle(1);
            send_beat(base + DW'(i), i == n - 1, err && (i == n - 1), mv && (i == n - 1), meta);
        end
    endtask

    task automatic do_free(input int w);
        i_free_valid = 1'b1; i_free_words = 5'(w);
        @(posedge clk);
        if (w <= m_commit - m_rd) m_rd += w; else m_ferr = 1;
        #1 i_free_valid = 1'b0;
    endtask

    task automatic pop_desc(output logic v, output logic [AW-1:0] a,
                            output logic [AW:0] w, output logic [15:0] l);
        i_desc_ready = 1'b1;
        @(negedge clk);
        v = o_desc_valid; a = o_desc_addr; w = o_desc_words; l = o_desc_len;
        @(posedge clk); #1 i_desc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (o_free_cnt !== 5'd16) begin errors++; $display("FAIL rst_free_cnt: got %0d required 16", o_free_cnt); end
        checks++; if ({o_mem_we, o_desc_valid, o_meta_ready, o_free_err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b required 0000", {o_mem_we, o_desc_valid, o_meta_ready, o_free_err}); end
        checks++; if ({o_drop_cnt, o_mem_waddr, o_desc_words} !== '0) begin errors++; $display("FAIL rst_values: got %h required 0", {o_drop_cnt, o_mem_waddr, o_desc_words}); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_reset();
        send_pkt(5, 32'hA0, 0, 1, 20, 0);
        @(negedge clk);
        checks++; if (o_desc_valid !== 1'b1) begin errors++; $display("FAIL basic_desc_latency: got %b required 1", o_desc_valid); end
        @(posedge clk); #1;
        idle(2);
        checks++; if (got_wr.size() != 5 || got_wr[4] !== {4'd4, 32'hA4}) begin errors++; $display("FAIL basic_last_write: got %0d entries required 5 ending 4:a4", got_wr.size()); end
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL basic_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL basic_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        checks++; if (o_free_cnt !== 5'd11) begin errors++; $display("FAIL basic_free_cnt: got %0d required 11", o_free_cnt); end
        checks++; if (got_meta != 1) begin errors++; $display("FAIL basic_meta_pulses: got %0d required 1", got_meta); end
        pop_desc(pv, pa, pw, pl);
        checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'd0, 5'd5, 16'd20}) begin errors++; $display("FAIL basic_desc: got %b/%0d/%0d/%0d required 1/0/5/20", pv, pa, pw, pl); end
    endtask

    task automatic test_error();
        do_reset();
        send_pkt(3, 32'hB0, 1, 1, 12, 0);
        send_pkt(2, 32'hC0, 0, 1, 7, 0);
        idle(2);
        checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL err_drop_cnt: got %0d required 1", o_drop_cnt); end
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL err_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL err_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        pop_desc(pv, pa, pw, pl);
        checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'd0, 5'd2, 16'd7}) begin errors++; $display("FAIL err_desc: got %b/%0d/%0d/%0d required 1/0/2/7", pv, pa, pw, pl); end
        @(negedge clk);
        checks++; if (o_desc_valid !== 1'b0) begin errors++; $display("FAIL err_no_extra_desc: got %b required 0", o_desc_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        do_reset();
        send_pkt(10, 32'h100, 0, 1, 40, 0);
        send_pkt(8, 32'h200, 0, 1, 32, 0);
        idle(2);
        checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d required 1", o_drop_cnt); end
        checks++; if (o_free_cnt !== 5'd6) begin errors++; $display("FAIL ovf_free_cnt: got %0d required 6", o_free_cnt); end
        checks++; if (got_wr.size() != 16 || got_wr[15] !== {4'd15, 32'h205}) begin errors++; $display("FAIL ovf_partial_writes: got %0d entries required 16 ending f:205", got_wr.size()); end
        do_free(10);
        idle(1);
        checks++; if (o_free_cnt !== 5'd16) begin errors++; $display("FAIL ovf_free_after_release: got %0d required 16", o_free_cnt); end
        send_pkt(4, 32'h300, 0, 1, 16, 0);
        idle(2);
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL ovf_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL ovf_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        while (m_desc.size() > 0) begin
            ed = m_desc.pop_front();
            pop_desc(pv, pa, pw, pl);
            checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'(ed.addr), 5'(ed.words), 16'(ed.len)}) begin errors++; $display("FAIL ovf_desc: got %b/%0d/%0d/%0d required 1/%0d/%0d/%0d", pv, pa, pw, pl, ed.addr, ed.words, ed.len); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send_pkt(14, 32'h400, 0, 1, 56, 0);
        ed = m_desc.pop_front();
        pop_desc(pv, pa, pw, pl);
        do_free(14);
        send_pkt(4, 32'h500, 0, 1, 13, 0);
        idle(2);
        checks++; if (got_wr.size() != 18 || got_wr[16][DW +: AW] !== 4'd0 || got_wr[15][DW +: AW] !== 4'd15) begin errors++; $display("FAIL wrap_addresses: got %0d entries required 18 wrapping 15->0", got_wr.size()); end
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL wrap_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL wrap_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        pop_desc(pv, pa, pw, pl);
        checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'd14, 5'd4, 16'd13}) begin errors++; $display("FAIL wrap_desc: got %b/%0d/%0d/%0d required 1/14/4/13", pv, pa, pw, pl); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(1, 32'h600 + DW'(i), 0, 1, i + 1, 0);
        idle(1);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b required 0", s_ready); end
        @(posedge clk); #1;
        ed = m_desc.pop_front();
        pop_desc(pv, pa, pw, pl);
        checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'd0, 5'd1, 16'd1}) begin errors++; $display("FAIL full_first_desc: got %b/%0d/%0d/%0d required 1/0/1/1", pv, pa, pw, pl); end
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b required 1", s_ready); end
        @(posedge clk); #1;
        send_pkt(1, 32'h6AA, 0, 1, 5, 0);
        idle(2);
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL full_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL full_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        while (m_desc.size() > 0) begin
            ed = m_desc.pop_front();
            pop_desc(pv, pa, pw, pl);
            checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'(ed.addr), 5'(ed.words), 16'(ed.len)}) begin errors++; $display("FAIL full_desc: got %b/%0d/%0d/%0d required 1/%0d/%0d/%0d", pv, pa, pw, pl, ed.addr, ed.words, ed.len); end
        end
    endtask

    task automatic test_free_err_reset();
        do_reset();
        do_free(3);
        idle(1);
        checks++; if (o_free_err !== 1'b1 || o_free_cnt !== 5'd16) begin errors++; $display("FAIL bad_free: got err=%b cnt=%0d required err=1 cnt=16", o_free_err, o_free_cnt); end
        send_pkt(1, 32'h700, 1, 0, 0, 0);
        send_beat(32'h710, 0, 0, 0, 0);
        send_beat(32'h711, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready: got %b required 0", s_ready); end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if ({o_mem_we, o_desc_valid, o_free_err, o_drop_cnt, o_free_cnt} !== {3'b000, 16'd0, 5'd16}) begin errors++; $display("FAIL midrst_outputs: got we=%b dv=%b ferr=%b drop=%0d free=%0d required 0/0/0/0/16", o_mem_we, o_desc_valid, o_free_err, o_drop_cnt, o_free_cnt); end
        @(posedge clk); #1;
        send_pkt(2, 32'h800, 0, 1, 8, 0);
        idle(2);
        checks++; if (got_wr.size() != 2 || got_wr[0] !== {4'd0, 32'h800}) begin errors++; $display("FAIL midrst_restart: got %0d entries required 2 starting 0:800", got_wr.size()); end
        pop_desc(pv, pa, pw, pl);
        checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'd0, 5'd2, 16'd8}) begin errors++; $display("FAIL midrst_desc: got %b/%0d/%0d/%0d required 1/0/2/8", pv, pa, pw, pl); end
    endtask

    task automatic test_random();
        int len, w;
        do_reset();
        for (int p = 0; p < 40; p++) begin
            if (m_desc.size() > 0 && (m_desc.size() == DD || $urandom % 3 == 0)) begin
                ed = m_desc.pop_front();
                pop_desc(pv, pa, pw, pl);
                checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'(ed.addr), 5'(ed.words), 16'(ed.len)}) begin errors++; $display("FAIL rnd_desc: got %b/%0d/%0d/%0d required 1/%0d/%0d/%0d", pv, pa, pw, pl, ed.addr, ed.words, ed.len); end
            end
            if ($urandom % 3 == 0) begin
                w = ($urandom % 10 == 0) ? (m_commit - m_rd + 1) : int'($urandom_range(0, m_commit - m_rd));
                do_free(w);
            end
            len = $urandom_range(1, 12);
            send_pkt(len, $urandom, ($urandom % 8 == 0), ($urandom % 8 != 0), $urandom_range(1, 999), 1);
            @(negedge clk);
            checks++; if (o_free_cnt !== 5'(RING - (m_wr - m_rd)) || o_drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd_counts[%0d]: got free=%0d drop=%0d required free=%0d drop=%0d", p, o_free_cnt, o_drop_cnt, RING - (m_wr - m_rd), m_drop); end
            @(posedge clk); #1;
        end
        idle(2);
        checks++; if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rnd_wr_count: got %0d required %0d", got_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rnd_wr[%0d]: got %h required %h", i, got_wr[i], exp_wr[i]); end end
        checks++; if (got_meta != m_meta || o_free_err !== m_ferr) begin errors++; $display("FAIL rnd_meta_ferr: got meta=%0d ferr=%b required meta=%0d ferr=%b", got_meta, o_free_err, m_meta, m_ferr); end
        while (m_desc.size() > 0) begin
            ed = m_desc.pop_front();
            pop_desc(pv, pa, pw, pl);
            checks++; if ({pv, pa, pw, pl} !== {1'b1, 4'(ed.addr), 5'(ed.words), 16'(ed.len)}) begin errors++; $display("FAIL rnd_tail_desc: got %b/%0d/%0d/%0d required 1/%0d/%0d/%0d", pv, pa, pw, pl, ed.addr, ed.words, ed.len); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_overflow();
        test_wrap();
        test_fifo_full();
        test_free_err_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pbm_wr_ctrl.md
# pbm_wr_ctrl

Packet-buffer write controller between the RX parser's PBM write interface and the packet buffer RAM. It owns a word-addressed ring buffer and writes each accepted payload beat to it. Each error-free packet is committed as a descriptor (start address, word count, payload byte length). Errored or overflowing packets are rolled back, so the downstream consumer only ever sees complete, valid packets, which it releases in order.

## Interface
- DATA_WIDTH, 32, payload beat width
- ADDR_WIDTH, 10, ring depth = 2^ADDR_WIDTH words
- DESC_DEPTH, 8, descriptor FIFO entries (power of 2, ≥2)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- s_wdata  in  DATA_WIDTH  payload beat from parser
- s_wvalid  in  1  beat valid
- s_wlast  in  1  last beat of packet
- s_werror  in  1  packet error flag, sampled on last beat
- s_ready  out  1  beat accept; a beat is accepted when s_wvalid && s_ready
- i_meta_data  in  16  payload byte length, valid with last beat
- i_meta_valid  in  1  meta valid
- o_meta_ready  out  1  meta consumed (pulse on committed last beat)
- o_mem_we  out  1  RAM write enable
- o_mem_waddr  out  ADDR_WIDTH  RAM word address
- o_mem_wdata  out  DATA_WIDTH  RAM write data
- o_desc_valid  out  1  descriptor available (FIFO head)
- o_desc_addr  out  ADDR_WIDTH  packet start word
- o_desc_words  out  ADDR_WIDTH+1  packet word count
- o_desc_len  out  16  payload byte length
- i_desc_ready  in  1  pop descriptor
- i_free_valid  in  1  consumer releases the oldest packet
- i_free_words  in  ADDR_WIDTH+1  words released
- o_free_cnt  out  ADDR_WIDTH+1  free words (registered)
- o_drop_cnt  out  16  dropped packets, saturating at 0xFFFF
- o_free_err  out  1  sticky: invalid free request seen

## Operation
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1). RAM address = low ADDR_WIDTH bits.
  - wr_ptr: speculative write position
  - commit_ptr: end of the last committed packet
  - rd_ptr: released boundary
- space = 2^ADDR_WIDTH − (wr_ptr − rd_ptr).
- FSM states: IDLE, WRITE, DISCARD.
- IDLE:
  - s_ready = !desc_fifo_full.
  - An accepted beat starts a packet: start_addr ← commit_ptr, and the beat is handled as in WRITE.
- WRITE: s_ready = 1. For each accepted beat:
  - space==0: beat is not written; wr_ptr ← commit_ptr. If s_wlast, drop_cnt++ and go to IDLE; else go to DISCARD.
  - otherwise: write beat at wr_ptr, then wr_ptr++.
  - s_wlast && !s_werror && i_meta_valid: commit. commit_ptr ← wr_ptr+1, push {start_addr, words, i_meta_data}, pulse o_meta_ready, go to IDLE.
  - s_wlast with s_werror or !i_meta_valid: write the beat, then rollback (wr_ptr ← commit_ptr), drop_cnt++, go to IDLE.
- DISCARD: s_ready = 1. Beats are consumed and not written. On the last beat, drop_cnt++ and go to IDLE.
- Free:
  - On i_free_valid, if i_free_words ≤ (commit_ptr − rd_ptr), then rd_ptr += i_free_words.
  - Otherwise the request is ignored and o_free_err is set; only rst clears it.
- Every packet has ≥1 beat. Word count range is 1..2^ADDR_WIDTH.

## Timing
- Reset values: all pointers 0, state IDLE, desc FIFO empty. All outputs 0 (s_ready forced 0 while rst high), except o_free_cnt = 2^ADDR_WIDTH.
- s_ready is combinational from state and FIFO-full.
- RAM write outputs are registered: a beat accepted at cycle T appears at o_mem_we/waddr/wdata in T+1.
- Descriptor FIFO is show-ahead: commit at T gives o_desc_valid at T+1 if the FIFO was empty.
- A pop is i_desc_ready && o_desc_valid. A simultaneous push and pop while full is impossible, because IDLE gates new packets on full.
- A free at T affects space from T+1. A beat at T uses pre-free space.
- A free and a commit in the same cycle are both applied.
- o_free_cnt is updated at T+1 for any pointer change at T.
- A rollback at T frees space from T+1.
- Reset mid-packet: the partial packet is lost without drop_cnt++. All pointers and the FIFO are cleared next cycle. Upstream must be reset concurrently.

## Test plan
Tests use ADDR_WIDTH=4 and DESC_DEPTH=4.
- 5-beat packet 0xA0..0xA4, meta 20, no error → RAM writes to addr 0..4 at T+1..T+5; desc {0,5,20} valid the cycle after the last beat; o_free_cnt=11; o_meta_ready pulses once.
- 3-beat packet with s_werror on last → no descriptor; o_drop_cnt=1; the next 2-beat good packet is written to addr 0..1 with desc {0,2,len}.
- Commit a 10-word packet (not freed), then send an 8-beat packet → 6 beats written to 10..15, the 7th beat triggers DISCARD, o_drop_cnt=1, o_free_cnt=6. Then free 10 → o_free_cnt=16, and a 4-beat packet lands at addr 10..13.
- Ring wrap: fill 14 words, free 14, send a 4-beat packet → writes to 14,15,0,1; desc {14,4,len}.
- Four 1-beat packets with i_desc_ready=0 → s_ready stays 0 in IDLE. Pop one → s_ready=1 the next cycle, and the fifth packet is accepted.
- i_free_words=3 with nothing committed → ignored, o_free_err=1. Assert rst mid-packet → all outputs return to reset values next cycle, and the next packet starts at addr 0.
